// File: rtl/ddr3_init_refresh_seq_pkg.sv
// DDR3 init/refresh sequencer shared definitions:
// timing defaults, command encodings, MR values, FSM states.
package ddr3_seq_pkg;

  localparam int TW = 12;
  localparam int RW = 12;
  localparam int PW = 4;

  localparam int T_RST_CYC    = 200;
  localparam int T_CKE_CYC    = 500;
  localparam int T_XPR_CYC    = 72;
  localparam int T_MRD_CYC    = 4;
  localparam int T_MOD_CYC    = 12;
  localparam int T_ZQINIT_CYC = 512;
  localparam int T_RP_CYC     = 6;
  localparam int T_RFC_CYC    = 44;
  localparam int T_REFI_CYC   = 3120;
  localparam int MAX_POSTPONE = 8;

  localparam logic [12:0] MR0_VAL = 13'h0520;
  localparam logic [12:0] MR1_VAL = 13'h0006;
  localparam logic [12:0] MR2_VAL = 13'h0000;
  localparam logic [12:0] MR3_VAL = 13'h0000;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;
  localparam logic [3:0] CMD_DES  = 4'b1111;

  localparam logic [12:0] A10 = 13'h0400;

  typedef enum logic [3:0] {
    S_RST_LO,
    S_CKE_WAIT,
    S_XPR,
    S_MR2,
    S_MR3,
    S_MR1,
    S_MR0,
    S_ZQ,
    S_IDLE,
    S_REQ,
    S_PREA,
    S_REF
  } state_e;

  // A wait of t cycles starting at a command edge
  // expires t edges later, so the timer loads t-1.
  function automatic logic [TW-1:0] wait_ld(int t);
    return TW'(t - 1);
  endfunction

endpackage

// File: rtl/ddr3_init_refresh_seq_if.sv
// DDR3 sequencer bus: refresh handshake, status, DDR3 pins.
// master = sequencer, slave = controller / command mux.
interface ddr3_init_refresh_seq_if;
  logic        init_done;
  logic        ref_req;
  logic        ref_ack;
  logic        ref_urgent;
  logic        bus_own;
  logic        reset_n;
  logic        cke;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic        odt;
  logic [2:0]  ba;
  logic [12:0] addr;

  modport master (
    output init_done, ref_req, ref_urgent,
    output bus_own, reset_n, cke,
    output cs_n, ras_n, cas_n, we_n, odt,
    output ba, addr,
    input  ref_ack
  );

  modport slave (
    input  init_done, ref_req, ref_urgent,
    input  bus_own, reset_n, cke,
    input  cs_n, ras_n, cas_n, we_n, odt,
    input  ba, addr,
    output ref_ack
  );
endinterface

// File: rtl/ddr3_init_refresh_seq_wait_timer.sv
// Down-counter for init and refresh waits.
// load/load_val restart it; done is high while count is 0.
module ddr3_wait_timer
  import ddr3_seq_pkg::*;
#(
  parameter int RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= TW'(RST_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ddr3_init_refresh_seq.sv
// DDR3 power-up init and periodic auto-refresh sequencer.
// Ports: clk, rst (async, high), bus (master modport).
module ddr3_init_refresh_seq
  import ddr3_seq_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  ddr3_init_refresh_seq_if.master        bus
);

  localparam logic [PW-1:0] MAXP = PW'(MAX_POSTPONE);

  state_e state_q, state_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  logic [3:0]    cmd_q, cmd_d;
  logic [2:0]    ba_q, ba_d;
  logic [12:0]   addr_q, addr_d;
  logic          rstn_q, rstn_d;
  logic          cke_q, cke_d;
  logic          done_q, done_d;
  logic          own_q, own_d;
  logic          req_q, req_d;
  logic          urg_q, urg_d;
  logic          ref_issue;

  logic [RW-1:0] refi_q;
  logic          refi_hit;
  logic [PW-1:0] pend_q, pend_d;

  ddr3_wait_timer #(
    .RST_VAL (T_RST_CYC)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RST_LO;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    cmd_d     = CMD_DES;
    ba_d      = '0;
    addr_d    = '0;
    rstn_d    = rstn_q;
    cke_d     = cke_q;
    done_d    = done_q;
    own_d     = own_q;
    ref_issue = 1'b0;
    unique case (state_q)
      S_RST_LO: if (tmr_done) begin
        rstn_d   = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = wait_ld(T_CKE_CYC);
        state_d  = S_CKE_WAIT;
      end
      S_CKE_WAIT: if (tmr_done) begin
        cke_d    = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = wait_ld(T_XPR_CYC);
        state_d  = S_XPR;
      end
      S_XPR: if (tmr_done) begin
        cmd_d    = CMD_MRS;
        ba_d     = 3'd2;
        addr_d   = MR2_VAL;
        tmr_load = 1'b1;
        tmr_val  = wait_ld(T_MRD_CYC);
        state_d  = S_MR2;
      end
      S_MR2: if (tmr_done) begin
        cmd_d    = CMD_MRS;
        ba_d     = 3'd3;
        addr_d   = MR3_VAL;
        tmr_load = 1'b1;
        tmr_val  = wait_ld(T_MRD_CYC);
        state_d  = S_MR3;
      end
      S_MR3: if (tmr_done) begin
        cmd_d    = CMD_MRS;
        ba_d     = 3'd1;
        addr_d   = MR1_VAL;
        tmr_load = 1'b1;
        tmr_val  = wait_ld(T_MRD_CYC);
        state_d  = S_MR1;
      end
      S_MR1: if (tmr_done) begin
        cmd_d    = CMD_MRS;
        ba_d     = 3'd0;
        addr_d   = MR0_VAL;
        tmr_load = 1'b1;
        tmr_val  = wait_ld(T_MOD_CYC);
        state_d  = S_MR0;
      end
      S_MR0: if (tmr_done) begin
        cmd_d    = CMD_ZQCL;
        addr_d   = A10;
        tmr_load = 1'b1;
        tmr_val  = wait_ld(T_ZQINIT_CYC);
        state_d  = S_ZQ;
      end
      S_ZQ: if (tmr_done) begin
        done_d  = 1'b1;
        own_d   = 1'b0;
        state_d = S_IDLE;
      end
      S_IDLE, S_REQ: begin
        if (req_q && bus.ref_ack) begin
          cmd_d    = CMD_PRE;
          addr_d   = A10;
          own_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = wait_ld(T_RP_CYC);
          state_d  = S_PREA;
        end else if (pend_q != '0 || refi_hit) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREA: if (tmr_done) begin
        cmd_d     = CMD_REF;
        ref_issue = 1'b1;
        tmr_load  = 1'b1;
        tmr_val   = wait_ld(T_RFC_CYC);
        state_d   = S_REF;
      end
      S_REF: if (tmr_done) begin
        // Drain further pending refreshes back to back
        if (pend_q != '0) begin
          cmd_d     = CMD_REF;
          ref_issue = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = wait_ld(T_RFC_CYC);
        end else begin
          own_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_RST_LO;
    endcase
  end

  // REFI runs only after init; reload coincides with init_done
  assign refi_hit = done_q && (refi_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refi_q <= '0;
    end else if (state_q == S_ZQ && tmr_done) begin
      refi_q <= RW'(T_REFI_CYC - 1);
    end else if (done_q) begin
      if (refi_hit) refi_q <= RW'(T_REFI_CYC - 1);
      else          refi_q <= refi_q - 1'b1;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (refi_hit && !ref_issue) begin
      if (pend_q != MAXP) pend_d = pend_q + 1'b1;
    end else if (ref_issue && !refi_hit) begin
      pend_d = pend_q - 1'b1;
    end
  end

  assign req_d = (state_d == S_IDLE || state_d == S_REQ)
              && (pend_d != '0);
  assign urg_d = (pend_d == MAXP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cmd_q  <= CMD_DES;
      ba_q   <= '0;
      addr_q <= '0;
      rstn_q <= 1'b0;
      cke_q  <= 1'b0;
      done_q <= 1'b0;
      own_q  <= 1'b1;
      req_q  <= 1'b0;
      urg_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cmd_q  <= cmd_d;
      ba_q   <= ba_d;
      addr_q <= addr_d;
      rstn_q <= rstn_d;
      cke_q  <= cke_d;
      done_q <= done_d;
      own_q  <= own_d;
      req_q  <= req_d;
      urg_q  <= urg_d;
    end
  end

  assign bus.cs_n       = cmd_q[3];
  assign bus.ras_n      = cmd_q[2];
  assign bus.cas_n      = cmd_q[1];
  assign bus.we_n       = cmd_q[0];
  assign bus.ba         = ba_q;
  assign bus.addr       = addr_q;
  assign bus.reset_n    = rstn_q;
  assign bus.cke        = cke_q;
  assign bus.odt        = 1'b0;
  assign bus.init_done  = done_q;
  assign bus.bus_own    = own_q;
  assign bus.ref_req    = req_q;
  assign bus.ref_urgent = urg_q;

endmodule

// File: tb/tb_ddr3_init_refresh_seq.sv
// Bench for ddr3_init_refresh_seq: event-level refresh model,
// scoreboard matched against pin/status events at negedge.
`timescale 1ns/1ps
module tb_ddr3_init_refresh_seq;

  localparam int T_RST    = 200;
  localparam int T_CKE    = 500;
  localparam int T_XPR    = 72;
  localparam int T_MRD    = 4;
  localparam int T_MOD    = 12;
  localparam int T_ZQINIT = 512;
  localparam int T_RP     = 6;
  localparam int T_RFC    = 44;
  localparam int T_REFI   = 3120;
  localparam int MAXP     = 8;

  typedef enum int {
    K_RSTN, K_CKE, K_CMD, K_DONE, K_BUS, K_REQ, K_URG
  } kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [19:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = -1;

  int pend;
  int next_exp;
  int idle_start;

  ddr3_init_refresh_seq_if bus();

  ddr3_init_refresh_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input int c, input kind_e k,
                      input logic [19:0] v);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic pend_inc(input int e);
    if (pend < MAXP) begin
      pend++;
      if (pend == MAXP) push(e, K_URG, 20'd1);
    end
  endtask

  task automatic add_exp_before(input int t);
    while (next_exp < t) begin
      pend_inc(next_exp);
      next_exp += T_REFI;
    end
  endtask

  task automatic push_init();
    int t;
    t = T_RST;
    push(t, K_RSTN, 20'd1);
    t += T_CKE;
    push(t, K_CKE, 20'd1);
    t += T_XPR;
    push(t, K_CMD, {4'b0000, 3'd2, 13'h0000});
    t += T_MRD;
    push(t, K_CMD, {4'b0000, 3'd3, 13'h0000});
    t += T_MRD;
    push(t, K_CMD, {4'b0000, 3'd1, 13'h0006});
    t += T_MRD;
    push(t, K_CMD, {4'b0000, 3'd0, 13'h0520});
    t += T_MOD;
    push(t, K_CMD, {4'b0110, 3'd0, 13'h0400});
    t += T_ZQINIT;
    push(t, K_DONE, 20'd1);
    push(t, K_BUS, 20'd0);
    pend       = 0;
    idle_start = t;
    next_exp   = t + T_REFI;
  endtask

  // One refresh session: request, PRE after d cycles of
  // waiting, REF drain, bus release.
  task automatic model_session(input int d, output int q,
                               output int a, output int c);
    int r;
    if (pend == 0) q = next_exp;
    else           q = idle_start;
    add_exp_before(q + 1);
    push(q, K_REQ, 20'd1);
    a = q + d;
    push(a, K_CMD, {4'b0010, 3'd0, 13'h0400});
    push(a, K_BUS, 20'd1);
    push(a, K_REQ, 20'd0);
    r = a + T_RP;
    forever begin
      add_exp_before(r);
      if (next_exp == r) begin
        next_exp += T_REFI;
      end else begin
        if (pend == MAXP) push(r, K_URG, 20'd0);
        pend--;
      end
      push(r, K_CMD, {4'b0001, 3'd0, 13'h0000});
      c = r + T_RFC;
      add_exp_before(c);
      if (pend > 0) r = c;
      else break;
    end
    push(c, K_BUS, 20'd0);
    idle_start = c;
    if (next_exp == c) begin
      pend_inc(c);
      next_exp += T_REFI;
    end
  endtask

  // Ack is random while the request is low, 0 while it
  // is high and waiting, 1 for the edge that takes it.
  task automatic drive_to(input int a, input int q);
    int n;
    while (cyc < a) begin
      n = cyc + 1;
      if (n == a)     bus.ref_ack = 1'b1;
      else if (n > q) bus.ref_ack = 1'b0;
      else bus.ref_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic run_session(input int d, output int c);
    int q;
    int a;
    model_session(d, q, a, c);
    drive_to(a, q);
  endtask

  task automatic check_reset(input string tag);
    logic [26:0] got;
    logic [26:0] req;
    got = {bus.reset_n, bus.cke, bus.cs_n, bus.ras_n,
           bus.cas_n, bus.we_n, bus.odt, bus.init_done,
           bus.ref_req, bus.ref_urgent, bus.bus_own,
           bus.ba, bus.addr};
    req = {1'b0, 1'b0, 4'b1111, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b1, 3'd0, 13'd0};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL reset_%s: got %h required %h",
               tag, got, req);
    end
  endtask

  task automatic observe(input kind_e k,
                         input logic [19:0] v);
    int idx;
    idx = -1;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].cyc == cyc
          && exp_q[i].kind == k) idx = i;
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected %s @%0d: got %h required none",
               k.name(), cyc, v);
    end else begin
      if (exp_q[idx].val !== v) begin
        errors++;
        $display("FAIL %s @%0d: got %h required %h",
                 k.name(), cyc, v, exp_q[idx].val);
      end
      exp_q.delete(idx);
    end
  endtask

  logic p_rstn, p_cke, p_done, p_own, p_req, p_urg;

  initial begin
    forever begin
      @(negedge clk);
      if (rst || cyc < 0) begin
        p_rstn = 1'b0;
        p_cke  = 1'b0;
        p_done = 1'b0;
        p_own  = 1'b1;
        p_req  = 1'b0;
        p_urg  = 1'b0;
      end else begin
        if (bus.reset_n !== p_rstn)
          observe(K_RSTN, 20'(bus.reset_n));
        if (bus.cke !== p_cke)
          observe(K_CKE, 20'(bus.cke));
        if (bus.cs_n !== 1'b1)
          observe(K_CMD, {bus.cs_n, bus.ras_n, bus.cas_n,
                          bus.we_n, bus.ba, bus.addr});
        if (bus.init_done !== p_done)
          observe(K_DONE, 20'(bus.init_done));
        if (bus.bus_own !== p_own)
          observe(K_BUS, 20'(bus.bus_own));
        if (bus.ref_req !== p_req)
          observe(K_REQ, 20'(bus.ref_req));
        if (bus.ref_urgent !== p_urg)
          observe(K_URG, 20'(bus.ref_urgent));
        p_rstn = bus.reset_n;
        p_cke  = bus.cke;
        p_done = bus.init_done;
        p_own  = bus.bus_own;
        p_req  = bus.ref_req;
        p_urg  = bus.ref_urgent;
        checks++;
        if (bus.odt !== 1'b0) begin
          errors++;
          $display("FAIL odt @%0d: got %b required 0",
                   cyc, bus.odt);
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
          if (exp_q[i].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missing %s @%0d: got none required %h",
                     exp_q[i].kind.name(), exp_q[i].cyc,
                     exp_q[i].val);
            exp_q.delete(i);
          end
        end
      end
    end
  end

  initial begin
    int c;
    int stop;
    bus.ref_ack = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    push_init();
    rst = 1'b0;

    run_session(1, c);
    run_session(T_REFI - T_RP, c);
    run_session(9 * T_REFI + $urandom_range(1, 200), c);
    run_session($urandom_range(1, 300), c);
    run_session($urandom_range(1, 50), c);

    stop = cyc + T_RP + T_RFC / 2;
    drive_to(stop, stop + 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset("async");
    repeat (3) @(negedge clk);
    check_reset("held");
    push_init();
    rst = 1'b0;

    run_session(1, c);
    bus.ref_ack = 1'b0;
    while (cyc < c + 5) @(negedge clk);

    foreach (exp_q[i]) begin
      checks++;
      errors++;
      $display("FAIL leftover %s @%0d: got none required %h",
               exp_q[i].kind.name(), exp_q[i].cyc,
               exp_q[i].val);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
